// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator: runs one move command as a train of fixed-width
// step pulses paced by rising edges of the divider tick. `STEPPER_POSITION_EN adds pos.
module stepper_pulse_gen #(
  parameter int unsigned STEPS_BITS   = 16,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned PULSE_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [STEPS_BITS-1:0] cmd_steps,
  output logic                  step,
  output logic                  dir,
  output logic                  busy,
  output logic                  done
`ifdef STEPPER_POSITION_EN
  ,
  output logic signed [STEPS_BITS:0] pos
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    PULSE,
    FINISH
  } state_t;

  localparam logic [PULSE_BITS-1:0] PULSE_LOAD = PULSE_BITS'(PULSE_CYCLES - 1);

  state_t                  state;
  state_t                  state_d;
  logic                    tick_q;
  logic                    tick_rise;
  logic [STEPS_BITS-1:0]   remaining;
  logic [PULSE_BITS-1:0]   pcnt;
  logic                    accept;
  logic                    fire;
  logic                    pulse_end;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    fire      = 1'b0;
    pulse_end = 1'b0;
    tick_rise = tick & ~tick_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_steps == '0) ? FINISH : SETUP;
        end
      end
      SETUP: state_d = WAIT;
      WAIT: begin
        if (tick_rise) begin
          fire    = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
        // rising ticks seen here are simply ignored, so they are never queued
        if (pcnt == '0) begin
          pulse_end = 1'b1;
          state_d   = (remaining == '0) ? FINISH : WAIT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      remaining <= '0;
      pcnt      <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      tick_q <= tick;
      done   <= 1'b0;
      if (accept) begin
        dir       <= cmd_dir;
        remaining <= cmd_steps;
        busy      <= 1'b1;
      end
      if (fire) begin
        step      <= 1'b1;
        pcnt      <= PULSE_LOAD;
        remaining <= remaining - STEPS_BITS'(1);
      end else if (state == PULSE && pcnt != '0) begin
        pcnt <= pcnt - PULSE_BITS'(1);
      end
      if (pulse_end) begin
        step <= 1'b0;
      end
      if (state == FINISH) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

`ifdef STEPPER_POSITION_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
    end else if (clk_en && fire) begin
      pos <= dir ? pos + (STEPS_BITS+1)'(1) : pos - (STEPS_BITS+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: directed vector table, hand sequences for reset,
// handshake timing and clk_en freeze, then randomized moves against a transaction-level model.
module tb_stepper_pulse_gen;

  localparam int SB = 16;
  localparam int PC = 4;

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          tick;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [SB-1:0] cmd_steps;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
`ifdef STEPPER_POSITION_EN
  logic signed [SB:0] pos;
  logic signed [SB:0] pos_exp;
  longint             pos_ref;
`endif

  stepper_pulse_gen #(
    .STEPS_BITS  (SB),
    .PULSE_CYCLES(PC),
    .PULSE_BITS  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .tick     (tick),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .step     (step),
    .dir      (dir),
    .busy     (busy),
    .done     (done)
`ifdef STEPPER_POSITION_EN
    ,
    .pos      (pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;

  // stimulus control
  int  tick_period = 10;
  bit  tick_square = 1'b0;
  int  tick_cnt = 0;
  int  en_pct = 100;
  bit  freeze_req = 1'b0;
  int  freeze_left = 0;
  logic exp_dir = 1'b0;

  // monitor state
  bit  hs;
  int  qcount = 0;
  int  hs_q, first_q, last_fall_q, done_q;
  int  pulses, width, width_err, dir_err, rise_err, done_cnt, held_cnt;
  bit  step_prev = 1'b0;
  bit  qtick_prev = 1'b0;

  typedef struct {
    logic          d;
    logic [SB-1:0] n;
    int            per;
    bit            sq;
    int            exp_pulses;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: let the edge happen, observe, then drive inputs for the next edge.
  task automatic advance();
    bit ready_pre;
    ready_pre = cmd_ready;
    @(posedge clk);
    #1;
    hs = clk_en && !reset && cmd_valid && ready_pre;
    if (reset) begin
      qtick_prev = 1'b0;
      step_prev  = 1'b0;
      width      = 0;
    end else if (clk_en) begin
      qcount++;
      if (hs) hs_q = qcount;
      if (step && !step_prev) begin
        pulses++;
        width = 1;
        if (first_q < 0) first_q = qcount;
        if (!(tick && !qtick_prev)) rise_err++;
      end else if (step) begin
        width++;
      end else if (step_prev) begin
        last_fall_q = qcount;
        if (width != PC) width_err++;
      end
      if (done) begin
        done_cnt++;
        done_q = qcount;
      end
      qtick_prev = tick;
      step_prev  = step;
    end else if (step) begin
      held_cnt++;
    end
    if (step && dir !== exp_dir) dir_err++;

    tick_cnt = (tick_cnt + 1) % tick_period;
    tick = tick_square ? (tick_cnt < tick_period / 2) : (tick_cnt == 0);
    if (freeze_req && step && width == 2) begin
      freeze_req  = 1'b0;
      freeze_left = 5;
    end
    if (freeze_left > 0) begin
      clk_en = 1'b0;
      freeze_left--;
    end else begin
      clk_en = ($urandom_range(99) < en_pct);
    end
  endtask

  task automatic clear_monitor();
    pulses = 0; width_err = 0; dir_err = 0; rise_err = 0;
    done_cnt = 0; held_cnt = 0; first_q = -1; hs_q = 0; last_fall_q = 0; done_q = 0;
  endtask

  // Issue one move and judge it purely from the observed pin behaviour.
  task automatic run_move(input logic d, input logic [SB-1:0] n, input int per, input bit sq,
                          input int enp, input int exp_p, input string tag);
    int budget;
    int limit;
    tick_period = per;
    tick_square = sq;
    en_pct      = enp;
    exp_dir     = d;
    clear_monitor();
    cmd_dir   = d;
    cmd_steps = n;
    cmd_valid = 1'b1;
    budget = 0;
    do begin
      advance();
      budget++;
    end while (!hs && budget < 200);
    cmd_valid = 1'b0;
    check({tag, " accepted"}, hs, 1);
    limit  = 400 + int'(n) * per * 20;
    budget = 0;
    while (done_cnt == 0 && budget < limit) begin
      advance();
      budget++;
    end
    check({tag, " timeout"}, (budget >= limit), 0);
    repeat (3 * per + 8) advance();
    check({tag, " pulses"}, pulses, exp_p);
    check({tag, " width errors"}, width_err, 0);
    check({tag, " dir errors"}, dir_err, 0);
    check({tag, " step without tick edge"}, rise_err, 0);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " busy after"}, busy, 0);
    check({tag, " ready after"}, cmd_ready, 1);
    check({tag, " dir held"}, dir, d);
    if (exp_p > 0) begin
      check({tag, " dir setup before first step"}, (first_q - hs_q >= 2), 1);
      check({tag, " done after last fall"}, done_q - last_fall_q, 1);
    end else begin
      check({tag, " done after handshake"}, done_q - hs_q, 1);
    end
`ifdef STEPPER_POSITION_EN
    pos_ref = pos_ref + (d ? longint'(n) : -longint'(n));
    pos_exp = pos_ref[SB:0];
    check({tag, " pos"}, longint'(pos), longint'(pos_exp));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'd3, 10, 1'b0, 3};
    vecs[1] = '{1'b0, 16'd0, 10, 1'b0, 0};
    vecs[2] = '{1'b1, 16'd2,  3, 1'b0, 2};
    vecs[3] = '{1'b0, 16'd4,  7, 1'b1, 4};
    vecs[4] = '{1'b1, 16'd1,  6, 1'b1, 1};

    reset = 1'b1; clk_en = 1'b1; tick = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
`ifdef STEPPER_POSITION_EN
    pos_ref = 0;
`endif
    clear_monitor();

    // reset held two cycles with a toggling tick
    tick_period = 2; tick_square = 1'b1; en_pct = 100;
    repeat (2) begin
      advance();
      check("reset step", step, 0);
      check("reset busy", busy, 0);
    end
    reset = 1'b0;
    advance();
    check("post-reset ready", cmd_ready, 1);
    check("post-reset dir", dir, 0);
    check("post-reset done", done, 0);
    repeat (10) advance();
    check("idle no pulses", pulses, 0);
    check("idle busy", busy, 0);

    foreach (vecs[i]) begin
      run_move(vecs[i].d, vecs[i].n, vecs[i].per, vecs[i].sq, 100, vecs[i].exp_pulses,
               $sformatf("vec%0d", i));
    end

    // zero-step command with a second command held waiting
    en_pct = 100; clear_monitor();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = '0;
    advance();
    check("zero hs", hs, 1);
    check("zero busy", busy, 1);
    check("zero ready in finish", cmd_ready, 0);
    check("zero done early", done, 0);
    cmd_dir = 1'b0;
    advance();
    check("finish not accepting", hs, 0);
    check("zero done", done, 1);
    check("zero busy cleared", busy, 0);
    check("ready with done", cmd_ready, 1);
    advance();
    check("back-to-back hs", hs, 1);
    check("back-to-back busy", busy, 1);
    check("back-to-back done cleared", done, 0);
    check("back-to-back dir", dir, 0);
    cmd_valid = 1'b0;
    repeat (3) advance();
    check("two zero moves done", done_cnt, 2);
    check("zero moves no pulses", pulses, 0);
`ifdef STEPPER_POSITION_EN
    check("zero moves pos", longint'(pos), pos_ref);
`endif

    // clk_en dropped for 5 cycles in the middle of a pulse
    freeze_req = 1'b1;
    run_move(1'b1, 16'd2, 10, 1'b0, 100, 2, "freeze");
    check("freeze held cycles", held_cnt, 5);

    // reset in the middle of a pulse
    tick_period = 10; tick_square = 1'b0; en_pct = 100; exp_dir = 1'b1;
    clear_monitor();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5;
    for (int k = 0; k < 50 && !hs; k++) advance();
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && !step; k++) advance();
    check("abort reached pulse", step, 1);
    advance();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    check("abort step", step, 0);
    check("abort done", done, 0);
    check("abort busy", busy, 0);
    check("abort ready", cmd_ready, 1);
`ifdef STEPPER_POSITION_EN
    pos_ref = 0;
    check("abort pos", longint'(pos), 0);
`endif
    clear_monitor();
    repeat (30) advance();
    check("abort no done", done_cnt, 0);
    check("abort no pulses", pulses, 0);
    run_move(1'b1, 16'd3, 8, 1'b0, 100, 3, "after abort +3");
    run_move(1'b0, 16'd1, 8, 1'b1, 100, 1, "after abort -1");
`ifdef STEPPER_POSITION_EN
    check("pos +3 -1", longint'(pos), 2);
`endif

    // randomized moves with random tick rate/shape and clk_en duty
    for (int r = 0; r < 24; r++) begin
      logic          d;
      logic [SB-1:0] n;
      int            per;
      bit            sq;
      int            enp;
      d   = 1'($urandom_range(1));
      n   = SB'($urandom_range(8));
      per = int'($urandom_range(12, 2));
      sq  = 1'($urandom_range(1));
      enp = int'($urandom_range(100, 60));
      run_move(d, n, per, sq, enp, int'(n), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
